segasys1_sndcmd_latch: RTL and testbench

Sound-side command receiver for the System 1/2 main-to-sound link. It captures the main CPU's sound command byte (`SNDNO`) on each rising edge of `SNDRQ`, then raises a timed NMI to the sound Z80. It presents the byte on the sound CPU's command read port and clears the request when the sound CPU reads it. It sits between the main-board outputs and the sound CPU core inside the sound subsystem.

---
 rtl/segasys1_sndcmd_latch.sv | 182 ++++++++++++++++++
 tb/tb_segasys1_sndcmd_latch.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segasys1_sndcmd_latch.sv
// Sound command receiver: captures SNDNO on SNDRQ rise, then issues a timed NMI.
// Define SNDCMD_FIFO_EN to replace the single overwrite latch with a FIFO.
module segasys1_sndcmd_latch #(
    parameter int NMI_WIDTH = 160,
    parameter int FIFO_AW   = 2
) (
    input  logic       CLK40M,
    input  logic       RESET_N,
    input  logic       SNDRQ,
    input  logic [7:0] SNDNO,
    input  logic       CPU_CE,
    input  logic       CPU_RD_CMD,
    output logic [7:0] CPU_DO,
    output logic       NMI_N,
    output logic       PENDING,
    output logic       OVERRUN
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(NMI_WIDTH - 1);

    logic   rq_prev_q;
    logic   new_cmd;
    logic   rd_req;
    logic   consume;
    logic   nonempty;
    logic   ovr_q, ovr_d;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic   rdseen_q, rdseen_d;

    assign new_cmd = SNDRQ & ~rq_prev_q;
    assign rd_req  = CPU_RD_CMD & CPU_CE;

`ifdef SNDCMD_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW:0]   fcnt_q, fcnt_d;
    logic               full;
    logic               push;

    assign nonempty = (fcnt_q != '0);
    assign full     = (fcnt_q == FULL_CNT);
    assign consume  = rd_req & nonempty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = new_cmd & (~full | consume);

    always_comb begin
        mem_d  = mem_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        fcnt_d = fcnt_q;
        ovr_d  = new_cmd & full & ~consume;
        if (push) begin
            mem_d[wptr_q] = SNDNO;
            wptr_d        = wptr_q + 1'b1;
        end
        if (consume) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, consume})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge CLK40M or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rptr_q <= '0;
            wptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign CPU_DO = mem_q[rptr_q];
`else
    logic [7:0] latch_q, latch_d;
    logic       pend_q, pend_d;

    assign nonempty = pend_q;
    assign consume  = rd_req & pend_q;

    always_comb begin
        latch_d = latch_q;
        pend_d  = pend_q & ~consume;
        ovr_d   = new_cmd & pend_q & ~consume;
        if (new_cmd) begin
            latch_d = SNDNO;
            pend_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK40M or negedge RESET_N) begin
        if (!RESET_N) begin
            latch_q <= 8'h00;
            pend_q  <= 1'b0;
        end else begin
            latch_q <= latch_d;
            pend_q  <= pend_d;
        end
    end

    assign CPU_DO = latch_q;
`endif

    // rdseen marks a consume during the current NMI sequence; a store
    // still non-empty after such a read earns a fresh NMI
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdseen_d = rdseen_q | consume;
        unique case (state_q)
            S_IDLE: begin
                if (nonempty) begin
                    state_d = S_ASSERT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (!nonempty) begin
                    state_d = S_IDLE;
                end else if (rdseen_q) begin
                    state_d = S_ASSERT;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_ASSERT && state_q != S_ASSERT) begin
            rdseen_d = consume;
        end
    end

    always_ff @(posedge CLK40M or negedge RESET_N) begin
        if (!RESET_N) begin
            rq_prev_q <= 1'b1;
            ovr_q     <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            rdseen_q  <= 1'b0;
        end else begin
            rq_prev_q <= SNDRQ;
            ovr_q     <= ovr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdseen_q  <= rdseen_d;
        end
    end

    assign NMI_N   = (state_q != S_ASSERT);
    assign PENDING = nonempty;
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_segasys1_sndcmd_latch.sv
// Bench for segasys1_sndcmd_latch: directed NMI timing, vector table, random model.
// Latch-mode sections are replaced by a FIFO section when SNDCMD_FIFO_EN is set.
module tb_segasys1_sndcmd_latch;

    localparam int W = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sndrq = 1'b0;
    logic [7:0] sndno = 8'h00;
    logic       ce = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] cpu_do;
    logic       nmi_n;
    logic       pending;
    logic       overrun;

    int npass = 0;
    int ntot  = 0;
    int nfalls = 0;
    int lowrun = 0;
    bit mon_en = 1'b1;
    logic nmi_prev = 1'b1;

    segasys1_sndcmd_latch #(.NMI_WIDTH(W), .FIFO_AW(2)) dut (
        .CLK40M    (clk),
        .RESET_N   (rst_n),
        .SNDRQ     (sndrq),
        .SNDNO     (sndno),
        .CPU_CE    (ce),
        .CPU_RD_CMD(rd),
        .CPU_DO    (cpu_do),
        .NMI_N     (nmi_n),
        .PENDING   (pending),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Every completed NMI low pulse must last exactly W cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            lowrun = 0;
            nmi_prev = 1'b1;
        end else begin
            if (nmi_prev && !nmi_n) nfalls++;
            if (!nmi_n) lowrun++;
            else if (lowrun != 0) begin
                if (mon_en) check("nmi_width", lowrun, W);
                lowrun = 0;
            end
            nmi_prev = nmi_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rq);
        sndrq = rq;
        rd = 1'b0;
        ce = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] b);
        sndno = b;
        sndrq = 1'b1;
        tick();
        sndrq = 1'b0;
    endtask

    task automatic wait_nmi(input logic lvl, input int maxc, input string nm);
        int n = 0;
        while (nmi_n !== lvl && n < maxc) begin
            tick();
            n++;
        end
        check(nm, nmi_n, lvl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

`ifndef SNDCMD_FIFO_EN
    typedef struct {
        logic       rq;
        logic [7:0] no;
        logic       rd;
        logic       ce;
        logic [7:0] edo;
        logic       epend;
        logic       eovr;
    } vec_t;

    function automatic vec_t mk(input logic rq, input logic [7:0] no,
                                input logic r, input logic c,
                                input logic [7:0] edo, input logic ep,
                                input logic eo);
        vec_t v;
        v.rq = rq; v.no = no; v.rd = r; v.ce = c;
        v.edo = edo; v.epend = ep; v.eovr = eo;
        return v;
    endfunction
`endif

    initial begin
        int f0;
        int lowc;

        // Reset with SNDRQ already high: the level must not count as an edge
        sndrq = 1'b1;
        #1;
        check("rst_nmi", nmi_n, 1'b1);
        check("rst_pend", pending, 1'b0);
        check("rst_do", cpu_do, 8'h00);
        check("rst_ovr", overrun, 1'b0);
        #20 rst_n = 1'b1;
        f0 = nfalls;
        idle(20);
        check("rqhigh_pend", pending, 1'b0);
        check("rqhigh_nofall", nfalls - f0, 0);

        // Basic command: PENDING at edge N, NMI low from N+1 for W cycles
        sndrq = 1'b0;
        tick();
        sndno = 8'h5A;
        sndrq = 1'b1;
        tick();
        check("basic_pend", pending, 1'b1);
        check("basic_nmi_n", nmi_n, 1'b1);
        check("basic_do", cpu_do, 8'h5A);
        sndrq = 1'b0;
        tick();
        check("basic_nmi_n1", nmi_n, 1'b0);
        lowc = 1;
        while (nmi_n == 1'b0 && lowc < 1000) begin
            tick();
            if (nmi_n == 1'b0) lowc++;
        end
        check("basic_width", lowc, W);
        check("basic_pend2", pending, 1'b1);
        rd = 1'b1;
        ce = 1'b1;
        tick();
        rd = 1'b0;
        ce = 1'b0;
        check("basic_rd_pend", pending, 1'b0);
        f0 = nfalls;
        idle(300);
        check("basic_no_more", nfalls - f0, 0);

`ifndef SNDCMD_FIFO_EN
        // Overwrite while pending: one-cycle OVERRUN, single NMI
        do_reset(1'b0);
        f0 = nfalls;
        push(8'h11);
        tick();
        push(8'h22);
        check("ovr_pulse", overrun, 1'b1);
        check("ovr_do", cpu_do, 8'h22);
        tick();
        check("ovr_1cyc", overrun, 1'b0);
        idle(400);
        check("ovr_one_nmi", nfalls - f0, 1);
        check("ovr_pend", pending, 1'b1);

        // Read and new command in one cycle during the NMI
        do_reset(1'b0);
        f0 = nfalls;
        push(8'h5A);
        idle(10);
        check("sim_old", cpu_do, 8'h5A);
        sndno = 8'h33;
        sndrq = 1'b1;
        rd = 1'b1;
        ce = 1'b1;
        tick();
        sndrq = 1'b0;
        rd = 1'b0;
        ce = 1'b0;
        check("sim_do", cpu_do, 8'h33);
        check("sim_pend", pending, 1'b1);
        check("sim_ovr", overrun, 1'b0);
        idle(500);
        check("sim_two_nmi", nfalls - f0, 2);
        rd = 1'b1;
        ce = 1'b1;
        tick();
        rd = 1'b0;
        ce = 1'b0;
        check("sim_drain", pending, 1'b0);
        idle(300);
        check("sim_no_third", nfalls - f0, 2);
`else
        // FIFO: fifth push into a full FIFO is dropped, one NMI per entry
        do_reset(1'b0);
        f0 = nfalls;
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
            check($sformatf("fifo_ovr%0d", i), overrun, (i == 5));
            tick();
        end
        check("fifo_pend", pending, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) wait_nmi(1'b0, 20, "fifo_nmi_start");
            wait_nmi(1'b1, 400, "fifo_nmi_end");
            check($sformatf("fifo_do%0d", k), cpu_do, 8'(k + 1));
            rd = 1'b1;
            ce = 1'b1;
            tick();
            rd = 1'b0;
            ce = 1'b0;
        end
        check("fifo_empty", pending, 1'b0);
        idle(400);
        check("fifo_nmi_cnt", nfalls - f0, 4);
`endif

        // Reset in the middle of an NMI
        do_reset(1'b0);
        push(8'h77);
        wait_nmi(1'b0, 10, "mid_start");
        idle(50);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        sndrq = 1'b1;
        #1;
        check("mid_nmi", nmi_n, 1'b1);
        check("mid_pend", pending, 1'b0);
        check("mid_do", cpu_do, 8'h00);
        tick();
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        check("mid_rqhigh", pending, 1'b0);
        sndrq = 1'b0;
        tick();
        push(8'hAB);
        check("mid_after_pend", pending, 1'b1);
        check("mid_after_do", cpu_do, 8'hAB);
        tick();
        check("mid_after_nmi", nmi_n, 1'b0);
        wait_nmi(1'b1, 300, "mid_after_end");

`ifndef SNDCMD_FIFO_EN
        begin
            vec_t tbl[17];
            do_reset(1'b1);
            tbl[0]  = mk(1, 8'hAA, 0, 0, 8'h00, 0, 0);
            tbl[1]  = mk(0, 8'hAA, 0, 0, 8'h00, 0, 0);
            tbl[2]  = mk(1, 8'h5A, 0, 0, 8'h5A, 1, 0);
            tbl[3]  = mk(1, 8'h77, 0, 0, 8'h5A, 1, 0);
            tbl[4]  = mk(0, 8'h77, 0, 0, 8'h5A, 1, 0);
            tbl[5]  = mk(1, 8'h11, 0, 0, 8'h11, 1, 1);
            tbl[6]  = mk(0, 8'h11, 0, 0, 8'h11, 1, 0);
            tbl[7]  = mk(0, 8'h00, 1, 0, 8'h11, 1, 0);
            tbl[8]  = mk(0, 8'h00, 1, 1, 8'h11, 0, 0);
            tbl[9]  = mk(0, 8'h00, 1, 1, 8'h11, 0, 0);
            tbl[10] = mk(1, 8'h22, 0, 0, 8'h22, 1, 0);
            tbl[11] = mk(0, 8'h22, 0, 0, 8'h22, 1, 0);
            tbl[12] = mk(1, 8'h33, 1, 1, 8'h33, 1, 0);
            tbl[13] = mk(0, 8'h33, 1, 1, 8'h33, 0, 0);
            tbl[14] = mk(1, 8'h44, 0, 1, 8'h44, 1, 0);
            tbl[15] = mk(0, 8'h44, 0, 0, 8'h44, 1, 0);
            tbl[16] = mk(1, 8'h55, 1, 0, 8'h55, 1, 1);
            for (int i = 0; i < 17; i++) begin
                sndrq = tbl[i].rq;
                sndno = tbl[i].no;
                rd = tbl[i].rd;
                ce = tbl[i].ce;
                tick();
                check($sformatf("tbl%0d_do", i), cpu_do, tbl[i].edo);
                check($sformatf("tbl%0d_pend", i), pending, tbl[i].epend);
                check($sformatf("tbl%0d_ovr", i), overrun, tbl[i].eovr);
            end
        end

        // Random traffic against a behavioural model of the latch
        begin
            logic       m_prev;
            logic [7:0] m_latch;
            logic       m_pend;
            logic       m_ovr;
            logic       m_new;
            logic       m_cons;
            do_reset(1'b0);
            m_prev = 1'b0;
            m_latch = 8'h00;
            m_pend = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 3) == 0) sndrq = ~sndrq;
                sndno = 8'($urandom);
                rd = ($urandom_range(0, 19) == 0);
                ce = 1'($urandom_range(0, 1));
                m_new = sndrq && !m_prev;
                m_cons = rd && ce && m_pend;
                m_ovr = m_new && m_pend && !m_cons;
                if (m_new) m_latch = sndno;
                m_pend = m_new || (m_pend && !m_cons);
                m_prev = sndrq;
                tick();
                check("rnd_do", cpu_do, m_latch);
                check("rnd_pend", pending, m_pend);
                check("rnd_ovr", overrun, m_ovr);
            end
            sndrq = 1'b0;
            rd = 1'b0;
            ce = 1'b0;
            idle(400);
        end
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
